disp_frame_checker: RTL and testbench
=====================================

Name: disp_frame_checker

Overview:
- Pixel-clock-domain monitor on the display output (RGB, data-enable, vsync). Replaces per-pixel file dumps with in-line frame checking.
- Per frame it computes a CRC-32 over active pixels, counts pixels and lines, and checks that every line and the frame match the configured resolution.
- Optionally compares the CRC against an expected value. Runs continuously or captures a single frame.
- Parametrised in colour depth, resolution and vsync polarity. Used in simulation and as on-chip debug.

Parameters:
COLOR_W, 4, bits per colour channel; pixel word is {R,G,B} = 3*COLOR_W bits
H_ACTIVE, 1024, required active pixels per line
V_ACTIVE, 768, required active lines per frame
VS_POL, 0, vsync active level (0 = active-low)
PIX_W, 24, frame pixel counter width
LINE_W, 12, line and per-line pixel counter width
FCNT_W, 16, frame counter width

Ports:
PCK  in  1  pixel clock; single clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
ENABLE  in  1  checker enable
SINGLE  in  1  1 = capture one frame then hold
EXP_CRC  in  32  expected frame CRC
EXP_VALID  in  1  compare FRAME_CRC against EXP_CRC
VGA_R/VGA_G/VGA_B  in  COLOR_W each  pixel colour
VGA_DE  in  1  active-video enable
VGA_VS  in  1  vertical sync
BUSY  out  1  state is WAIT_SYNC or CAPTURE
FRAME_DONE  out  1  one-cycle pulse when frame results update
FRAME_CRC  out  32  CRC of last completed frame
FRAME_PIX  out  PIX_W  active pixels in last frame
FRAME_LINES  out  LINE_W  active lines in last frame
SIZE_ERR  out  1  last frame size wrong
CRC_ERR  out  1  last frame CRC mismatch
ERR_STICKY  out  1  OR of SIZE_ERR or CRC_ERR since enable
FRAME_CNT  out  FCNT_W  completed frames since enable, wraps

Behaviour:
- Reset: state IDLE. All outputs 0, including FRAME_CRC = 0. Internal vs_d, de_d = inactive, CRC accumulator = 0xFFFFFFFF, counters = 0.
- vs_act = (VGA_VS == VS_POL). vs_edge = vs_act & !vs_d. de_rise = VGA_DE & !de_d. de_fall = !VGA_DE & de_d.
- States:
  - IDLE: ENABLE=1 -> WAIT_SYNC. Result outputs hold their values.
  - WAIT_SYNC: vs_edge -> CAPTURE, clear accumulators. No FRAME_DONE.
  - CAPTURE: on vs_edge, close the frame (see below).
  - HOLD: reached after a frame closes with SINGLE=1 (SINGLE sampled at the closing edge).
  - ENABLE=0 in any state -> IDLE next cycle. Accumulators cleared, ERR_STICKY and FRAME_CNT cleared, a partial frame is discarded with no FRAME_DONE. HOLD leaves only through ENABLE=0.
- Frame close, on the cycle sampling vs_edge in CAPTURE:
  - Register FRAME_CRC, FRAME_PIX, FRAME_LINES, SIZE_ERR and CRC_ERR.
  - FRAME_DONE = 1 for exactly the following cycle.
  - FRAME_CNT increments. ERR_STICKY |= SIZE_ERR | CRC_ERR.
  - Accumulators restart for the next frame. Stay in CAPTURE, or go to HOLD if SINGLE=1.
- Pixel accumulation: each cycle with VGA_DE=1 in CAPTURE does the following.
  - CRC is updated with the pixel word {R,G,B}, MSB first. CRC-32 polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, no final XOR. The full pixel word is processed in one cycle.
  - Frame pixel count increments and saturates at all-ones.
  - Per-line count increments and saturates.
  - A pixel on the same cycle as vs_edge belongs to the new frame.
- Lines:
  - de_rise increments the line count (saturating) and zeroes the per-line count.
  - de_fall checks per-line count == H_ACTIVE. A mismatch sets the frame's line-length error flag.
  - A frame closed while DE=1 checks the open line too.
- SIZE_ERR = line-length error | lines != V_ACTIVE | pix != H_ACTIVE*V_ACTIVE.
- CRC_ERR = EXP_VALID & (crc != EXP_CRC), with EXP_VALID and EXP_CRC sampled at the close edge. CRC_ERR is 0 when EXP_VALID=0.
- Empty frame (no DE between syncs) gives CRC 0xFFFFFFFF, pix 0, lines 0, SIZE_ERR=1.
- RST during any state overrides ENABLE and restores reset values next cycle.

Test Plan:
- Reset and idle: assert RST with ENABLE=1 and toggling video -> all outputs 0, BUSY=0. After release -> BUSY=1 next cycle, no FRAME_DONE before the second vs_edge.
- H_ACTIVE=4, V_ACTIVE=3, COLOR_W=4, three correct frames of pixel 0xFFF -> FRAME_DONE on 2nd and 3rd vsync only. Each frame gives FRAME_PIX=12, FRAME_LINES=3, SIZE_ERR=0, FRAME_CNT=1 then 2. FRAME_CRC is identical across frames and equals the bench CRC model.
- Same configuration, line 2 has 3 pixels -> SIZE_ERR=1, FRAME_PIX=11. The next correct frame gives SIZE_ERR=0 with ERR_STICKY still 1. ENABLE=0 for one cycle -> ERR_STICKY=0, FRAME_CNT=0.
- EXP_VALID=1 with EXP_CRC = model CRC -> CRC_ERR=0. Flip bit 0 of one pixel -> CRC_ERR=1, ERR_STICKY=1. Empty frame -> FRAME_CRC=0xFFFFFFFF, FRAME_PIX=0, SIZE_ERR=1.
- SINGLE=1 -> exactly one FRAME_DONE, then BUSY=0. Outputs are unchanged over 3 more frames. An ENABLE drop mid-frame gives no FRAME_DONE. Re-enabling restarts from WAIT_SYNC.
- Default XGA, VS_POL=0, four horizontal bands (white, red, green, blue) of 192 lines each -> FRAME_PIX=786432, FRAME_LINES=768, SIZE_ERR=0, FRAME_CRC equal to the model value.

Source files
------------

// File: rtl/disp_frame_checker.sv
// In-line display frame checker: CRC-32 over active pixels plus pixel/line
// counts and resolution checks, one result set per vsync-delimited frame.
module disp_frame_checker #(
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int VS_POL   = 0,
    parameter int PIX_W    = 24,
    parameter int LINE_W   = 12,
    parameter int FCNT_W   = 16
) (
    input  logic                PCK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic                SINGLE,
    input  logic [31:0]         EXP_CRC,
    input  logic                EXP_VALID,
    input  logic [COLOR_W-1:0]  VGA_R,
    input  logic [COLOR_W-1:0]  VGA_G,
    input  logic [COLOR_W-1:0]  VGA_B,
    input  logic                VGA_DE,
    input  logic                VGA_VS,
    output logic                BUSY,
    output logic                FRAME_DONE,
    output logic [31:0]         FRAME_CRC,
    output logic [PIX_W-1:0]    FRAME_PIX,
    output logic [LINE_W-1:0]   FRAME_LINES,
    output logic                SIZE_ERR,
    output logic                CRC_ERR,
    output logic                ERR_STICKY,
    output logic [FCNT_W-1:0]   FRAME_CNT
);

    localparam int                PW       = 3 * COLOR_W;
    localparam logic [31:0]       POLY     = 32'h04C11DB7;
    localparam logic [31:0]       CRC_INIT = 32'hFFFFFFFF;
    localparam logic              VS_LVL   = 1'(VS_POL);
    localparam logic [LINE_W-1:0] H_REQ    = LINE_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] V_REQ    = LINE_W'(V_ACTIVE);
    localparam logic [PIX_W-1:0]  PIX_REQ  = PIX_W'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, HOLD} state_t;

    state_t              state_q, state_d;
    logic                vs_prev_q, de_prev_q;
    logic [31:0]         crc_q, crc_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   lines_q, lines_d;
    logic [LINE_W-1:0]   lpix_q, lpix_d;
    logic                lerr_q, lerr_d;
    logic [31:0]         fcrc_q, fcrc_d;
    logic [PIX_W-1:0]    fpix_q, fpix_d;
    logic [LINE_W-1:0]   flines_q, flines_d;
    logic                fsize_q, fsize_d;
    logic                fcerr_q, fcerr_d;
    logic                done_q, done_d;
    logic                sticky_q, sticky_d;
    logic [FCNT_W-1:0]   cnt_q, cnt_d;

    logic                vs_act, vs_edge, de_rise, de_fall;
    logic [PW-1:0]       pix_word;
    logic                close_lerr, close_size, close_cerr;

    // Whole pixel word folded into the CRC in one cycle, MSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PW-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = PW - 1; i >= 0; i--) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
        end
        return r;
    endfunction

    assign vs_act   = (VGA_VS == VS_LVL);
    assign vs_edge  = vs_act & ~vs_prev_q;
    assign de_rise  = VGA_DE & ~de_prev_q;
    assign de_fall  = ~VGA_DE & de_prev_q;
    assign pix_word = {VGA_R, VGA_G, VGA_B};

    // A line still open when the frame closes is checked along with the rest.
    assign close_lerr = lerr_q | (de_prev_q & (lpix_q != H_REQ));
    assign close_size = close_lerr | (lines_q != V_REQ) | (pix_q != PIX_REQ);
    assign close_cerr = EXP_VALID & (crc_q != EXP_CRC);

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        pix_d    = pix_q;
        lines_d  = lines_q;
        lpix_d   = lpix_q;
        lerr_d   = lerr_q;
        fcrc_d   = fcrc_q;
        fpix_d   = fpix_q;
        flines_d = flines_q;
        fsize_d  = fsize_q;
        fcerr_d  = fcerr_q;
        done_d   = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (!ENABLE) begin
            state_d  = IDLE;
            crc_d    = CRC_INIT;
            pix_d    = '0;
            lines_d  = '0;
            lpix_d   = '0;
            lerr_d   = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_SYNC;
                WAIT_SYNC, CAPTURE: begin
                    if (vs_edge) begin
                        if (state_q == CAPTURE) begin
                            fcrc_d   = crc_q;
                            fpix_d   = pix_q;
                            flines_d = lines_q;
                            fsize_d  = close_size;
                            fcerr_d  = close_cerr;
                            done_d   = 1'b1;
                            cnt_d    = cnt_q + FCNT_W'(1);
                            sticky_d = sticky_q | close_size | close_cerr;
                            state_d  = SINGLE ? HOLD : CAPTURE;
                        end else begin
                            state_d = CAPTURE;
                        end
                        // A pixel coinciding with the sync edge opens the new frame.
                        crc_d   = VGA_DE ? crc_step(CRC_INIT, pix_word) : CRC_INIT;
                        pix_d   = VGA_DE ? PIX_W'(1) : '0;
                        lines_d = de_rise ? LINE_W'(1) : '0;
                        lpix_d  = VGA_DE ? LINE_W'(1) : '0;
                        lerr_d  = 1'b0;
                    end else if (state_q == CAPTURE) begin
                        if (VGA_DE) begin
                            crc_d  = crc_step(crc_q, pix_word);
                            pix_d  = (pix_q == '1) ? pix_q : pix_q + PIX_W'(1);
                            lpix_d = de_rise ? LINE_W'(1)
                                   : ((lpix_q == '1) ? lpix_q : lpix_q + LINE_W'(1));
                        end
                        if (de_rise) begin
                            lines_d = (lines_q == '1) ? lines_q : lines_q + LINE_W'(1);
                        end
                        if (de_fall && (lpix_q != H_REQ)) begin
                            lerr_d = 1'b1;
                        end
                    end
                end
                HOLD: state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCK) begin
        if (RST) begin
            state_q   <= IDLE;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            crc_q     <= CRC_INIT;
            pix_q     <= '0;
            lines_q   <= '0;
            lpix_q    <= '0;
            lerr_q    <= 1'b0;
            fcrc_q    <= '0;
            fpix_q    <= '0;
            flines_q  <= '0;
            fsize_q   <= 1'b0;
            fcerr_q   <= 1'b0;
            done_q    <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_act;
            de_prev_q <= VGA_DE;
            crc_q     <= crc_d;
            pix_q     <= pix_d;
            lines_q   <= lines_d;
            lpix_q    <= lpix_d;
            lerr_q    <= lerr_d;
            fcrc_q    <= fcrc_d;
            fpix_q    <= fpix_d;
            flines_q  <= flines_d;
            fsize_q   <= fsize_d;
            fcerr_q   <= fcerr_d;
            done_q    <= done_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign BUSY        = (state_q == WAIT_SYNC) || (state_q == CAPTURE);
    assign FRAME_DONE  = done_q;
    assign FRAME_CRC   = fcrc_q;
    assign FRAME_PIX   = fpix_q;
    assign FRAME_LINES = flines_q;
    assign SIZE_ERR    = fsize_q;
    assign CRC_ERR     = fcerr_q;
    assign ERR_STICKY  = sticky_q;
    assign FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_disp_frame_checker.sv
// Scoreboard bench: two checker configurations; the stimulus pushes expected
// frame results, monitors pop and compare on every FRAME_DONE.
module tb_disp_frame_checker;

    logic PCK = 1'b0;
    always #5 PCK = ~PCK;

    logic        RST, a_en, b_en, single, exp_valid, b_exp_valid, b_single, b_rst;
    logic [31:0] exp_crc, b_exp_crc;
    int          cur;
    logic        vs_act, de;
    logic [23:0] rgb;
    logic        a_vs, a_de, b_vs, b_de;

    // Only the selected instance sees live video; the other sees idle sync.
    assign a_vs  = (cur == 0 && vs_act) ? 1'b0 : 1'b1;
    assign a_de  = (cur == 0) && de;
    assign b_vs  = (cur == 1) && vs_act;
    assign b_de  = (cur == 1) && de;
    assign b_rst = RST;

    logic        a_busy, a_done, a_size, a_cerr, a_sticky;
    logic [31:0] a_crc;
    logic [23:0] a_pix;
    logic [11:0] a_lines;
    logic [15:0] a_cnt;
    logic        b_busy, b_done, b_size, b_cerr, b_sticky;
    logic [31:0] b_crc;
    logic [23:0] b_pix;
    logic [11:0] b_lines;
    logic [15:0] b_cnt;

    disp_frame_checker #(.COLOR_W(4), .H_ACTIVE(4), .V_ACTIVE(3), .VS_POL(0)) u_a (
        .PCK(PCK), .RST(RST), .ENABLE(a_en), .SINGLE(single),
        .EXP_CRC(exp_crc), .EXP_VALID(exp_valid),
        .VGA_R(rgb[11:8]), .VGA_G(rgb[7:4]), .VGA_B(rgb[3:0]),
        .VGA_DE(a_de), .VGA_VS(a_vs),
        .BUSY(a_busy), .FRAME_DONE(a_done), .FRAME_CRC(a_crc), .FRAME_PIX(a_pix),
        .FRAME_LINES(a_lines), .SIZE_ERR(a_size), .CRC_ERR(a_cerr),
        .ERR_STICKY(a_sticky), .FRAME_CNT(a_cnt)
    );

    // Banded-colour frame on a smaller 24-bit configuration with active-high vsync.
    disp_frame_checker #(.COLOR_W(8), .H_ACTIVE(16), .V_ACTIVE(8), .VS_POL(1)) u_b (
        .PCK(PCK), .RST(b_rst), .ENABLE(b_en), .SINGLE(b_single),
        .EXP_CRC(b_exp_crc), .EXP_VALID(b_exp_valid),
        .VGA_R(rgb[23:16]), .VGA_G(rgb[15:8]), .VGA_B(rgb[7:0]),
        .VGA_DE(b_de), .VGA_VS(b_vs),
        .BUSY(b_busy), .FRAME_DONE(b_done), .FRAME_CRC(b_crc), .FRAME_PIX(b_pix),
        .FRAME_LINES(b_lines), .SIZE_ERR(b_size), .CRC_ERR(b_cerr),
        .ERR_STICKY(b_sticky), .FRAME_CNT(b_cnt)
    );

    typedef struct {
        logic [31:0] crc;
        int          pix;
        int          lines;
        bit          size;
        bit          cerr;
        bit          sticky;
        int          cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_crc;
    int          m_pix, m_lines;
    bit          m_lerr;
    bit          m_sticky[2];
    int          m_cnt[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC: data aligned to the top of the register, then shifted out.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] d, input int n);
        logic [31:0] r;
        r = c ^ (32'(d) << (32 - n));
        for (int i = 0; i < n; i++) begin
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    function automatic int hreq();
        return (cur == 1) ? 16 : 4;
    endfunction

    function automatic int vreq();
        return (cur == 1) ? 8 : 3;
    endfunction

    task automatic step();
        @(posedge PCK);
        #1;
    endtask

    task automatic vsync();
        m_crc = 32'hFFFFFFFF; m_pix = 0; m_lines = 0; m_lerr = 0;
        de = 0; vs_act = 1;
        step(); step();
        vs_act = 0;
        step(); step();
    endtask

    task automatic line(input int n, input logic [23:0] pix, input int flip_at);
        logic [23:0] p;
        for (int i = 0; i < n; i++) begin
            p = (i == flip_at) ? (pix ^ 24'h1) : pix;
            rgb = p; de = 1;
            m_crc = crc_model(m_crc, p, (cur == 1) ? 24 : 12);
            m_pix++;
            step();
        end
        de = 0; rgb = 0;
        m_lines++;
        if (n != hreq()) m_lerr = 1;
        step(); step();
    endtask

    task automatic frame(input int short_line, input int flip_line);
        for (int l = 0; l < vreq(); l++) begin
            line((l == short_line) ? hreq() - 1 : hreq(), 24'hFFF, (l == flip_line) ? 2 : -1);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.crc    = m_crc;
        e.pix    = m_pix;
        e.lines  = m_lines;
        e.size   = m_lerr || (m_lines != vreq()) || (m_pix != hreq() * vreq());
        e.cerr   = (cur == 0) && exp_valid && (m_crc != exp_crc);
        m_sticky[cur] = m_sticky[cur] | e.size | e.cerr;
        m_cnt[cur]++;
        e.sticky = m_sticky[cur];
        e.cnt    = m_cnt[cur];
        if (cur == 0) begin
            qa.push_back(e);
            last_a = e;
        end else begin
            qb.push_back(e);
        end
    endtask

    task automatic restart_a();
        a_en = 0; step();
        m_sticky[0] = 0; m_cnt[0] = 0;
        chk("disable_sticky", 64'(a_sticky), 64'(m_sticky[0]));
        chk("disable_cnt", 64'(a_cnt), 64'(m_cnt[0]));
        a_en = 1; step();
    endtask

    always @(negedge PCK) begin
        exp_t e;
        if (a_done) begin
            $display("frame done inst=A crc=%08h pix=%0d lines=%0d size_err=%0b crc_err=%0b sticky=%0b cnt=%0d",
                     a_crc, a_pix, a_lines, a_size, a_cerr, a_sticky, a_cnt);
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_done: got FRAME_DONE=1 expected 0 (cnt=%0d)", a_cnt);
            end else begin
                e = qa.pop_front();
                chk("a_crc", 64'(a_crc), 64'(e.crc));
                chk("a_pix", 64'(a_pix), 64'(e.pix));
                chk("a_lines", 64'(a_lines), 64'(e.lines));
                chk("a_size_err", 64'(a_size), 64'(e.size));
                chk("a_crc_err", 64'(a_cerr), 64'(e.cerr));
                chk("a_sticky", 64'(a_sticky), 64'(e.sticky));
                chk("a_cnt", 64'(a_cnt), 64'(e.cnt));
            end
        end
        if (b_done) begin
            $display("frame done inst=B crc=%08h pix=%0d lines=%0d size_err=%0b crc_err=%0b sticky=%0b cnt=%0d",
                     b_crc, b_pix, b_lines, b_size, b_cerr, b_sticky, b_cnt);
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_done: got FRAME_DONE=1 expected 0 (cnt=%0d)", b_cnt);
            end else begin
                e = qb.pop_front();
                chk("b_crc", 64'(b_crc), 64'(e.crc));
                chk("b_pix", 64'(b_pix), 64'(e.pix));
                chk("b_lines", 64'(b_lines), 64'(e.lines));
                chk("b_size_err", 64'(b_size), 64'(e.size));
                chk("b_crc_err", 64'(b_cerr), 64'(e.cerr));
                chk("b_sticky", 64'(b_sticky), 64'(e.sticky));
                chk("b_cnt", 64'(b_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        RST = 1; a_en = 1; b_en = 1; single = 0; b_single = 0;
        exp_valid = 0; exp_crc = 0; b_exp_valid = 0; b_exp_crc = 0;
        cur = 0; vs_act = 0; de = 0; rgb = 0;
        m_sticky[0] = 0; m_sticky[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;

        // Reset held with enable high and live video.
        step();
        vsync(); line(4, 24'hFFF, -1); vsync(); line(4, 24'hA5A, -1);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_crc", 64'(a_crc), 64'd0);
        chk("rst_pix", 64'(a_pix), 64'd0);
        chk("rst_lines", 64'(a_lines), 64'd0);
        chk("rst_size", 64'(a_size), 64'd0);
        chk("rst_cerr", 64'(a_cerr), 64'd0);
        chk("rst_sticky", 64'(a_sticky), 64'd0);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        RST = 0; step();
        chk("busy_after_rst", 64'(a_busy), 64'd1);

        // Correct frames: first vsync only opens capture.
        vsync();
        repeat (3) begin
            frame(-1, -1); push_exp(); vsync();
        end

        // Short line 2, then a correct frame with the sticky flag still set.
        frame(1, -1); push_exp(); vsync();
        frame(-1, -1); push_exp(); vsync();
        restart_a();

        // Expected-CRC comparison: match, single-bit corruption, empty frame.
        vsync();
        frame(-1, -1); exp_valid = 1; exp_crc = m_crc; push_exp(); vsync();
        frame(-1, 1); push_exp(); vsync();
        exp_valid = 0; push_exp(); vsync();
        chk("empty_crc", 64'(a_crc), 64'hFFFFFFFF);
        chk("empty_pix", 64'(a_pix), 64'd0);
        chk("empty_size", 64'(a_size), 64'd1);

        // Single capture then hold across further frames.
        restart_a();
        single = 1;
        vsync();
        frame(-1, -1); push_exp(); vsync();
        chk("hold_busy", 64'(a_busy), 64'd0);
        single = 0;
        repeat (3) begin
            frame(-1, 0); vsync();
        end
        chk("hold_crc", 64'(a_crc), 64'(last_a.crc));
        chk("hold_pix", 64'(a_pix), 64'(last_a.pix));
        chk("hold_cnt", 64'(a_cnt), 64'(last_a.cnt));
        chk("hold_busy_after", 64'(a_busy), 64'd0);

        // Enable dropped mid-frame discards the partial frame.
        restart_a();
        chk("reenable_busy", 64'(a_busy), 64'd1);
        vsync();
        line(4, 24'hFFF, -1); line(4, 24'hFFF, -1);
        a_en = 0; step();
        chk("drop_busy", 64'(a_busy), 64'd0);
        chk("drop_cnt", 64'(a_cnt), 64'd0);
        a_en = 1; step();
        chk("wait_sync_busy", 64'(a_busy), 64'd1);
        line(4, 24'hFFF, -1);
        vsync();
        frame(-1, -1); push_exp(); vsync();

        // Four colour bands, two lines each, on the second instance.
        cur = 1;
        vsync();
        for (int band = 0; band < 4; band++) begin
            for (int l = 0; l < 2; l++) begin
                case (band)
                    0: line(16, 24'hFFFFFF, -1);
                    1: line(16, 24'hFF0000, -1);
                    2: line(16, 24'h00FF00, -1);
                    default: line(16, 24'h0000FF, -1);
                endcase
            end
        end
        push_exp(); vsync();
        chk("band_pix", 64'(b_pix), 64'd128);
        chk("band_lines", 64'(b_lines), 64'd8);

        repeat (5) step();
        chk("a_pending", 64'(qa.size()), 64'd0);
        chk("b_pending", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
